// File: rtl/psum_accumulator.sv
// Multiplies IF x filter cells, accumulates one partial sum per output point and queues the
// finished psums in a small output FIFO. Optional macro PSUM_SAT_EN: saturating sums plus sat_flag.
module psum_accumulator #(
  parameter int IF_CELL_SIZE     = 8,
  parameter int FILTER_CELL_SIZE = 8,
  parameter int PSUM_SIZE        = 24,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        can_mult,
  input  logic                        par_done,
  input  logic                        Done,
  input  logic [IF_CELL_SIZE-1:0]     if_data,
  input  logic [FILTER_CELL_SIZE-1:0] filter_data,
  output logic                        stall,
  output logic [PSUM_SIZE-1:0]        psum_data,
  output logic                        psum_valid,
  input  logic                        psum_ready,
  output logic                        busy,
  output logic                        all_done,
  output logic                        overflow
`ifdef PSUM_SAT_EN
  ,
  output logic                        sat_flag
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

  state_t state, state_nxt;

  logic                        run_en, clear;
  logic signed [PSUM_SIZE-1:0] prod_ext, prod_p1, term, sum_nxt, acc, sum_p2;
  logic                        vld_p1, last_p1, vld_p2;
  logic [PSUM_SIZE-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W:0]              wr_ptr, rd_ptr, count;
  logic                        full, pop, push_ok, pipe_empty;

`ifdef PSUM_SAT_EN
  logic sat_hit;

  function automatic logic add_overflows(input logic signed [PSUM_SIZE-1:0] a,
                                         input logic signed [PSUM_SIZE-1:0] b);
    logic signed [PSUM_SIZE-1:0] s;
    s = a + b;
    return (a[PSUM_SIZE-1] == b[PSUM_SIZE-1]) && (s[PSUM_SIZE-1] != a[PSUM_SIZE-1]);
  endfunction

  function automatic logic signed [PSUM_SIZE-1:0] sat_add(input logic signed [PSUM_SIZE-1:0] a,
                                                          input logic signed [PSUM_SIZE-1:0] b);
    if (!add_overflows(a, b))
      return a + b;
    // Both operands share a sign on overflow; clamp toward that sign.
    return a[PSUM_SIZE-1] ? {1'b1, {(PSUM_SIZE-1){1'b0}}} : {1'b0, {(PSUM_SIZE-1){1'b1}}};
  endfunction
`else
  function automatic logic signed [PSUM_SIZE-1:0] wrap_add(input logic signed [PSUM_SIZE-1:0] a,
                                                           input logic signed [PSUM_SIZE-1:0] b);
    return a + b;
  endfunction
`endif

  assign run_en = (state == S_RUN);
  assign clear  = (state == S_IDLE) && start;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    all_done  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (Done) state_nxt = S_DRAIN;
      S_DRAIN:  if (pipe_empty && (count == '0)) state_nxt = S_FINISH;
      S_FINISH: begin
        all_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Stage 1: product register
  assign prod_ext = PSUM_SIZE'($signed(if_data)) * PSUM_SIZE'($signed(filter_data));

  always_ff @(posedge clk) begin
    prod_p1 <= prod_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= can_mult & run_en;
      last_p1 <= par_done & run_en;
    end
  end

  // Stage 2: accumulate, close the sum on last
  assign term = vld_p1 ? prod_p1 : '0;
`ifdef PSUM_SAT_EN
  assign sum_nxt = sat_add(acc, term);
  assign sat_hit = add_overflows(acc, term);
`else
  assign sum_nxt = wrap_add(acc, term);
`endif

  always_ff @(posedge clk) begin
    sum_p2 <= sum_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc    <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= last_p1;
      if (last_p1)     acc <= '0;
      else if (vld_p1) acc <= sum_nxt;
    end
  end

`ifdef PSUM_SAT_EN
  always_ff @(posedge clk) begin
    if (rst || clear)         sat_flag <= 1'b0;
    else if (vld_p1 && sat_hit) sat_flag <= 1'b1;
  end
`endif

  assign pipe_empty = !vld_p1 && !last_p1 && !vld_p2;

  // Stage 3: output FIFO
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign psum_valid = (count != '0);
  assign pop        = psum_valid && psum_ready;
  assign push_ok    = vld_p2 && (!full || pop);
  assign psum_data  = psum_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;

  // Counting the psum sitting in stage 1 keeps room for everything already in flight.
  assign stall = (CNT_W'(count) + CNT_W'(last_p1)) >= CNT_W'(FIFO_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= sum_p2;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (vld_p2 && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
